sobel_serial_rx: RTL and testbench
==================================

# sobel_serial_rx

- UART-style serial receiver front end of the Sobel edge-detection datapath.
- Detects start bits, samples each data bit at mid-bit, and checks the stop bit.
- Delivers each received pixel byte to the downstream pixel buffer over a valid/ready handshake.
- Uses a `flex_stp_sr` instance for bit assembly; this block supplies that instance's `shift_enable` and consumes its `parallel_out`.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; even, ≥ 4
- DATA_BITS, 8, data bits per frame (LSB first)

Ports:
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  reset; one clock; reset is asynchronous and active-low
- serial_in  in  1  asynchronous serial line, idle high
- rx_ready  in  1  downstream accepts rx_data this cycle
- clear_err  in  1  single-cycle pulse that clears both sticky error flags
- rx_data  out  DATA_BITS  received byte
- rx_valid  out  1  rx_data holds an unconsumed byte
- framing_error  out  1  sticky: a stop bit was sampled low
- overrun_error  out  1  sticky: a byte was dropped because rx_valid was still pending

## Operation
Reset:
- State is IDLE.
- Both synchronizer flops are 1.
- Counters, rx_data, rx_valid, framing_error and overrun_error are all 0.

Input path:
- serial_in passes through a 2-flop synchronizer; `rx_s` is the second flop.
- All sampling uses `rx_s`.

State machine:
- IDLE: when rx_s == 0, go to START and set clk_cnt = 0.
- START: count up. At clk_cnt == CLKS_PER_BIT/2-1, sample rx_s.
  - rx_s == 0: go to DATA with clk_cnt = 0, bit_cnt = 0.
  - rx_s == 1: treat as a glitch and return to IDLE.
- DATA: count up. At clk_cnt == CLKS_PER_BIT-1:
  - assert shift_enable for exactly one cycle (serial_in of the shift register = rx_s);
  - set clk_cnt = 0 and increment bit_cnt;
  - after the DATA_BITS-th shift, go to STOP.
- STOP: count up. At clk_cnt == CLKS_PER_BIT-1, sample rx_s.
  - rx_s == 1: load the byte and go to IDLE.
  - rx_s == 0: set framing_error, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s == 1, then go to IDLE. This prevents a stuck-low line from retriggering reception.

Byte load (good stop bit):
- rx_data <= shift-register parallel_out and rx_valid <= 1.
- If rx_valid is already 1 and rx_ready is 0 in the load cycle, the new byte overwrites rx_data and overrun_error is set.
- If rx_ready is 1 in the load cycle, the old byte counts as consumed, the new byte is loaded, rx_valid stays 1, and no overrun is flagged.

Handshake:
- rx_valid clears on any cycle with rx_valid && rx_ready and no load.
- rx_data is held stable while rx_valid == 1 and no load occurs.

Errors:
- clear_err clears both flags on the next edge.
- If clear_err coincides with a new error event, the set wins.

Reset mid-frame:
- Abort immediately to IDLE; all outputs return to their reset values.

Widths:
- clk_cnt is $clog2(CLKS_PER_BIT) bits.
- bit_cnt is $clog2(DATA_BITS+1) bits.
- Counters never wrap during a frame, because comparisons use terminal values.

## Timing
- Synchronizer latency: 2 cycles from a serial_in edge to rx_s.
- Start bit: mid-bit sample taken CLKS_PER_BIT/2 cycles after START entry.
- Each data bit and the stop bit: sampled exactly CLKS_PER_BIT cycles after the previous sample.
- rx_valid rises on the edge after the stop-bit sample cycle (1 cycle after the sample).
- Frame length: from the start-bit falling edge on rx_s to rx_valid, 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT cycles (±1 for edge alignment).
- Back-to-back frames: a start bit arriving on the cycle immediately after the stop-bit sample is detected from IDLE with no lost cycles.

## Structure
- Package `sobel_rx_pkg` holds:
  - typedef enum `rx_state_t` {IDLE, START, DATA, STOP, WAIT_IDLE};
  - the defaults CLKS_PER_BIT_DEF = 16 and DATA_BITS_DEF = 8.
- One sub-module: `flex_stp_sr` with NUM_BITS = DATA_BITS and SHIFT_MSB = 0 (LSB-first, so the first bit received ends up in bit 0).
- Its reset value of all-ones is internal only and never reaches rx_data, because rx_data loads only on a good stop bit.
- FSM, counters, output register and error flags live in this block.

## Test plan
- Single frame: serial 0xA5 (LSB first, stop = 1), CLKS_PER_BIT = 16, rx_ready = 1. Required: rx_data = 0xA5; rx_valid high for 1 cycle; both error flags 0.
- Glitch: serial_in low for 4 cycles, then high. Required: FSM returns to IDLE from START; rx_valid never rises.
- Framing: frame 0x3C with the stop bit held low for 3 bit times. Required:
  - framing_error = 1 and rx_valid stays 0;
  - no new frame starts until the line returns high;
  - a clear_err pulse afterwards clears the flag.
- Overrun: rx_ready = 0; send 0x11 then 0x22 back-to-back. Required: rx_data = 0x22, rx_valid = 1, overrun_error = 1.
- Simultaneous accept and load: assert rx_ready on the exact cycle the second byte 0x22 loads (after 0x11). Required: rx_data = 0x22, rx_valid = 1, overrun_error = 0.
- Reset mid-frame: drive n_rst low during the DATA state of a 0xFF frame. Required: all outputs 0 immediately; the next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/sobel_serial_rx_pkg.sv
// Shared types and default parameters for the Sobel serial receiver front end.
package sobel_rx_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_BITS_DEF    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/sobel_serial_rx_if.sv
// Byte delivery handshake between the serial receiver and the downstream pixel buffer.
interface sobel_serial_rx_if
    import sobel_rx_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/sobel_serial_rx_sr.sv
// Flexible serial-to-parallel shift register; SHIFT_MSB=0 shifts toward bit 0 (LSB-first framing).
module flex_stp_sr
    import sobel_rx_pkg::*;
#(
    parameter int NUM_BITS  = DATA_BITS_DEF,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);
    logic [NUM_BITS-1:0] shift_reg;
    logic [NUM_BITS-1:0] shift_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BITS; gi++) begin : g_bit
            if (SHIFT_MSB) begin : g_to_msb
                if (gi == 0) begin : g_in
                    assign shift_next[gi] = serial_in;
                end else begin : g_mid
                    assign shift_next[gi] = shift_reg[gi-1];
                end
            end else begin : g_to_lsb
                if (gi == NUM_BITS - 1) begin : g_in
                    assign shift_next[gi] = serial_in;
                end else begin : g_mid
                    assign shift_next[gi] = shift_reg[gi+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_reg <= '1;
        end else if (shift_enable) begin
            shift_reg <= shift_next;
        end
    end

    assign parallel_out = shift_reg;

endmodule

// File: rtl/sobel_serial_rx.sv
// UART-style receiver: start detection, mid-bit sampling, stop check, and a
// valid/ready byte register with sticky framing/overrun flags.
module sobel_serial_rx
    import sobel_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              serial_in,
    input  logic              clear_err,
    sobel_serial_rx_if.master rx_bus,
    output logic              framing_error,
    output logic              overrun_error
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 sync1_reg;
    logic                 rx_s_reg;
    rx_state_t            state_reg,   state_next;
    logic [CNT_W-1:0]     clk_cnt_reg, clk_cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 rx_valid_reg;
    logic                 framing_error_reg;
    logic                 overrun_error_reg;

    logic                 shift_enable;
    logic                 load_byte;
    logic                 stop_bad;
    logic [DATA_BITS-1:0] parallel_out;

    flex_stp_sr #(
        .NUM_BITS  (DATA_BITS),
        .SHIFT_MSB (1'b0)
    ) u_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (shift_enable),
        .serial_in    (rx_s_reg),
        .parallel_out (parallel_out)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_reg <= 1'b1;
            rx_s_reg  <= 1'b1;
        end else begin
            sync1_reg <= serial_in;
            rx_s_reg  <= sync1_reg;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg + 1'b1;
        bit_cnt_next = bit_cnt_reg;
        case (state_reg)
            IDLE: begin
                clk_cnt_next = '0;
                if (!rx_s_reg) state_next = START;
            end
            START: begin
                if (clk_cnt_reg == CNT_HALF) begin
                    clk_cnt_next = '0;
                    bit_cnt_next = '0;
                    state_next   = rx_s_reg ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_reg == CNT_LAST) begin
                    clk_cnt_next = '0;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == BIT_LAST) state_next = STOP;
                end
            end
            STOP: begin
                if (clk_cnt_reg == CNT_LAST) begin
                    clk_cnt_next = '0;
                    state_next   = rx_s_reg ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // Hold off until the line idles so a stuck-low line cannot retrigger.
                clk_cnt_next = '0;
                if (rx_s_reg) state_next = IDLE;
            end
            default: begin
                clk_cnt_next = '0;
                state_next   = IDLE;
            end
        endcase
    end

    always_comb begin
        shift_enable = (state_reg == DATA) && (clk_cnt_reg == CNT_LAST);
        load_byte    = (state_reg == STOP) && (clk_cnt_reg == CNT_LAST) && rx_s_reg;
        stop_bad     = (state_reg == STOP) && (clk_cnt_reg == CNT_LAST) && !rx_s_reg;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data_reg       <= '0;
            rx_valid_reg      <= 1'b0;
            framing_error_reg <= 1'b0;
            overrun_error_reg <= 1'b0;
        end else begin
            if (load_byte) begin
                rx_data_reg  <= parallel_out;
                rx_valid_reg <= 1'b1;
            end else if (rx_valid_reg && rx_bus.rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
            // A new error event takes priority over a coincident clear.
            framing_error_reg <= stop_bad || (framing_error_reg && !clear_err);
            overrun_error_reg <= (load_byte && rx_valid_reg && !rx_bus.rx_ready)
                              || (overrun_error_reg && !clear_err);
        end
    end

    assign rx_bus.rx_data  = rx_data_reg;
    assign rx_bus.rx_valid = rx_valid_reg;
    assign framing_error   = framing_error_reg;
    assign overrun_error   = overrun_error_reg;

endmodule

// File: tb/tb_sobel_serial_rx.sv
// Self-checking bench for sobel_serial_rx: directed scenarios plus randomized frames.
module tb_sobel_serial_rx;
    import sobel_rx_pkg::*;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic serial_in = 1'b1;
    logic clear_err = 1'b0;
    logic framing_error;
    logic overrun_error;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] got_q[$];
    int valid_cycles = 0;

    sobel_serial_rx_if #(.DATA_BITS(8)) rx_bus ();

    sobel_serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .clear_err     (clear_err),
        .rx_bus        (rx_bus.master),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    always #5 clk = ~clk;

    // Consumer-side observer: a byte is taken on every cycle with valid && ready.
    always @(negedge clk) begin
        if (n_rst) begin
            if (rx_bus.rx_valid) valid_cycles++;
            if (rx_bus.rx_valid && rx_bus.rx_ready) got_q.push_back(rx_bus.rx_data);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame: start bit, LSB-first data, then the stop level for stop_len bit times.
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
        serial_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            tick(CPB);
        end
        serial_in = stop_val;
        tick(CPB * stop_len);
        serial_in = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        total_cnt++;
        if (rx_bus.rx_valid !== 1'b0 || rx_bus.rx_data !== 8'h00) $display("FAIL reset_out: valid=%b data=%h want 0/00", rx_bus.rx_valid, rx_bus.rx_data);
        else pass_cnt++;
        total_cnt++;
        if (framing_error !== 1'b0 || overrun_error !== 1'b0) $display("FAIL reset_err: fe=%b oe=%b want 0/0", framing_error, overrun_error);
        else pass_cnt++;
        tick(1);
        n_rst = 1'b1;
        tick(3);
        total_cnt++;
        if (dut.state_reg !== IDLE || dut.rx_s_reg !== 1'b1) $display("FAIL reset_idle: state=%0d rx_s=%b want IDLE/1", dut.state_reg, dut.rx_s_reg);
        else pass_cnt++;
        $display("reset: done");
    endtask

    task automatic test_single_frame;
        int v0;
        logic [7:0] d;
        rx_bus.rx_ready = 1'b1;
        got_q.delete();
        v0 = valid_cycles;
        send_frame(8'hA5, 1'b1, 1);
        tick(CPB);
        d = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        total_cnt++;
        if (got_q.size() != 1 || d !== 8'hA5) $display("FAIL single_data: n=%0d data=%h want 1/a5", got_q.size(), d);
        else pass_cnt++;
        total_cnt++;
        if (valid_cycles - v0 != 1) $display("FAIL single_valid_len: cycles=%0d want 1", valid_cycles - v0);
        else pass_cnt++;
        total_cnt++;
        if (framing_error !== 1'b0 || overrun_error !== 1'b0) $display("FAIL single_err: fe=%b oe=%b want 0/0", framing_error, overrun_error);
        else pass_cnt++;
        $display("single: byte=%h", d);
    endtask

    task automatic test_glitch;
        int v0;
        bit saw_start = 0;
        v0 = valid_cycles;
        serial_in = 1'b0;
        tick(4);
        serial_in = 1'b1;
        for (int i = 0; i < 2 * CPB; i++) begin
            if (dut.state_reg == START) saw_start = 1;
            tick(1);
        end
        total_cnt++;
        if (!saw_start || dut.state_reg !== IDLE) $display("FAIL glitch_fsm: saw_start=%0d state=%0d want 1/IDLE", saw_start, dut.state_reg);
        else pass_cnt++;
        total_cnt++;
        if (valid_cycles != v0) $display("FAIL glitch_valid: cycles=%0d want 0", valid_cycles - v0);
        else pass_cnt++;
        $display("glitch: state=%0d", dut.state_reg);
    endtask

    task automatic test_framing;
        int v0;
        v0 = valid_cycles;
        // Leave the line low after the bad stop bit.
        serial_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            serial_in = 8'h3C >> i;
            tick(CPB);
        end
        serial_in = 1'b0;
        tick(3 * CPB);
        total_cnt++;
        if (framing_error !== 1'b1 || rx_bus.rx_valid !== 1'b0 || valid_cycles != v0) $display("FAIL framing_flag: fe=%b valid=%b cycles=%0d want 1/0/0", framing_error, rx_bus.rx_valid, valid_cycles - v0);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_reg !== WAIT_IDLE) $display("FAIL framing_hold: state=%0d want WAIT_IDLE", dut.state_reg);
        else pass_cnt++;
        serial_in = 1'b1;
        tick(4);
        total_cnt++;
        if (dut.state_reg !== IDLE) $display("FAIL framing_release: state=%0d want IDLE", dut.state_reg);
        else pass_cnt++;
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        total_cnt++;
        if (framing_error !== 1'b0) $display("FAIL framing_clear: fe=%b want 0", framing_error);
        else pass_cnt++;
        $display("framing: flagged and cleared");
    endtask

    task automatic test_overrun;
        logic [7:0] d;
        rx_bus.rx_ready = 1'b0;
        got_q.delete();
        send_frame(8'h11, 1'b1, 1);
        send_frame(8'h22, 1'b1, 1);
        total_cnt++;
        if (rx_bus.rx_data !== 8'h22 || rx_bus.rx_valid !== 1'b1 || overrun_error !== 1'b1) $display("FAIL overrun: data=%h valid=%b oe=%b want 22/1/1", rx_bus.rx_data, rx_bus.rx_valid, overrun_error);
        else pass_cnt++;
        rx_bus.rx_ready = 1'b1;
        tick(1);
        rx_bus.rx_ready = 1'b0;
        d = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        total_cnt++;
        if (got_q.size() != 1 || d !== 8'h22 || rx_bus.rx_valid !== 1'b0) $display("FAIL overrun_drain: n=%0d data=%h valid=%b want 1/22/0", got_q.size(), d, rx_bus.rx_valid);
        else pass_cnt++;
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        total_cnt++;
        if (overrun_error !== 1'b0) $display("FAIL overrun_clear: oe=%b want 0", overrun_error);
        else pass_cnt++;
        $display("overrun: byte=%h", d);
    endtask

    task automatic test_accept_on_load;
        bit found = 0;
        logic [7:0] d;
        rx_bus.rx_ready = 1'b0;
        got_q.delete();
        send_frame(8'h11, 1'b1, 1);
        fork
            send_frame(8'h22, 1'b1, 1);
            begin
                for (int i = 0; i < 12 * CPB; i++) begin
                    if (dut.state_reg == STOP && dut.clk_cnt_reg == 4'(CPB - 1) && dut.rx_s_reg) begin
                        found = 1;
                        rx_bus.rx_ready = 1'b1;
                        tick(1);
                        rx_bus.rx_ready = 1'b0;
                        break;
                    end
                    tick(1);
                end
            end
        join
        total_cnt++;
        if (!found) $display("FAIL accept_load_timeout: load cycle not seen within %0d cycles", 12 * CPB);
        else pass_cnt++;
        d = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        total_cnt++;
        if (got_q.size() != 1 || d !== 8'h11) $display("FAIL accept_load_old: n=%0d data=%h want 1/11", got_q.size(), d);
        else pass_cnt++;
        total_cnt++;
        if (rx_bus.rx_data !== 8'h22 || rx_bus.rx_valid !== 1'b1 || overrun_error !== 1'b0) $display("FAIL accept_load_new: data=%h valid=%b oe=%b want 22/1/0", rx_bus.rx_data, rx_bus.rx_valid, overrun_error);
        else pass_cnt++;
        rx_bus.rx_ready = 1'b1;
        tick(1);
        $display("accept_on_load: held=%h", rx_bus.rx_data);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        bit in_data = 0;
        rx_bus.rx_ready = 1'b0;
        send_frame(8'h77, 1'b1, 1);
        send_frame(8'h66, 1'b1, 1);
        fork
            send_frame(8'hFF, 1'b1, 1);
            begin
                tick(3 * CPB);
                in_data = (dut.state_reg == DATA);
                n_rst = 1'b0;
                #1;
                total_cnt++;
                if (rx_bus.rx_valid !== 1'b0 || rx_bus.rx_data !== 8'h00 || framing_error !== 1'b0 || overrun_error !== 1'b0) $display("FAIL midreset_out: valid=%b data=%h fe=%b oe=%b want 0/00/0/0", rx_bus.rx_valid, rx_bus.rx_data, framing_error, overrun_error);
                else pass_cnt++;
                total_cnt++;
                if (!in_data || dut.state_reg !== IDLE) $display("FAIL midreset_fsm: was_data=%0d state=%0d want 1/IDLE", in_data, dut.state_reg);
                else pass_cnt++;
            end
        join
        tick(2);
        n_rst = 1'b1;
        tick(4);
        rx_bus.rx_ready = 1'b1;
        got_q.delete();
        send_frame(8'h5A, 1'b1, 1);
        tick(CPB);
        d = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        total_cnt++;
        if (got_q.size() != 1 || d !== 8'h5A) $display("FAIL midreset_next: n=%0d data=%h want 1/5a", got_q.size(), d);
        else pass_cnt++;
        $display("reset_mid_frame: next byte=%h", d);
    endtask

    // Random bytes with random gaps (including back-to-back) and occasional bad stop bits.
    task automatic test_random_frames;
        logic [7:0] exp_q[$];
        logic exp_fe = 1'b0;
        logic [7:0] b;
        logic [7:0] d;
        bit good;
        rx_bus.rx_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 4) != 0);
            send_frame(b, good, 1);
            if (good) exp_q.push_back(b);
            else begin
                exp_fe = 1'b1;
                tick(2 * CPB);
            end
            tick($urandom_range(0, 3));
        end
        tick(CPB);
        total_cnt++;
        if (got_q.size() != exp_q.size()) $display("FAIL random_count: got=%0d want %0d", got_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size(); i++) begin
            d = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total_cnt++;
            if (d !== exp_q[i]) $display("FAIL random_byte[%0d]: got=%h want %h", i, d, exp_q[i]);
            else pass_cnt++;
            $display("random: frame %0d byte=%h", i, d);
        end
        total_cnt++;
        if (framing_error !== exp_fe || overrun_error !== 1'b0) $display("FAIL random_err: fe=%b oe=%b want %b/0", framing_error, overrun_error, exp_fe);
        else pass_cnt++;
    endtask

    initial begin
        rx_bus.rx_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_glitch();
        test_framing();
        test_overrun();
        test_accept_on_load();
        test_reset_mid_frame();
        test_random_frames();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
